// File: rtl/rto_time_controller.sv
// rto_time_controller
//   Timebase generator for the RTO cores and the TTLx8 output stage. It owns the shared
//   counter and emits a one-cycle auto_start strobe whenever the timebase enters RUNNING.
//   Commands (LOAD/START/STOP/CLEAR) arrive over a valid/ready port. START carries an arm
//   delay, so several boards can begin counting on a common cycle.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   cmd_valid   command present
//   cmd_ready   command accepted when cmd_valid && cmd_ready
//   cmd_op      0=LOAD, 1=START, 2=STOP, 3=CLEAR
//   cmd_data    LOAD: new counter value; START: arm delay in [DELAY_WIDTH-1:0]
//   counter     timebase to the RTO cores
//   auto_start  one-cycle strobe on entry to RUNNING
//   running     high while in RUNNING
//   state       0=IDLE, 1=ARMED, 2=RUNNING, 3=PAUSED
//   cmd_error   one-cycle pulse on an illegal command
//   wrap_error  sticky, set when the counter wraps; cleared by reset or CLEAR
module rto_time_controller #(
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned DELAY_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [63:0]              cmd_data,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic                     auto_start,
  output logic                     running,
  output logic [1:0]               state,
  output logic                     cmd_error,
  output logic                     wrap_error
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StRunning = 2'd2,
    StPaused  = 2'd3
  } state_e;

  localparam logic [1:0] OpLoad  = 2'd0;
  localparam logic [1:0] OpStart = 2'd1;
  localparam logic [1:0] OpStop  = 2'd2;
  localparam logic [1:0] OpClear = 2'd3;

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [DELAY_WIDTH-1:0]   delay_q, delay_d;
  logic                     auto_start_q, auto_start_d;
  logic                     running_q;
  logic                     cmd_error_q, cmd_error_d;
  logic                     wrap_error_q, wrap_error_d;
  logic                     cmd_ready_q;

  logic                     accept;
  logic                     idle_or_paused;
  logic [DELAY_WIDTH-1:0]   cmd_delay;

  // Upper cmd_data bits are ignored for START and for narrow counters.
  logic unused_cmd_data;
  assign unused_cmd_data = ^cmd_data;

  assign accept         = cmd_valid && cmd_ready_q;
  assign idle_or_paused = (state_q == StIdle) || (state_q == StPaused);
  assign cmd_delay      = cmd_data[DELAY_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    delay_d      = delay_q;
    auto_start_d = 1'b0;
    cmd_error_d  = 1'b0;
    wrap_error_d = wrap_error_q;

    // Autonomous progress; an accepted command below may override it.
    unique case (state_q)
      StArmed: begin
        if (delay_q == '0) begin
          state_d      = StRunning;
          auto_start_d = 1'b1;
        end else begin
          delay_d = delay_q - DELAY_WIDTH'(1);
        end
      end
      StRunning: begin
        counter_d = counter_q + COUNTER_WIDTH'(1);
        if (&counter_q) begin
          wrap_error_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      unique case (cmd_op)
        OpLoad: begin
          if (idle_or_paused) begin
            counter_d = cmd_data[COUNTER_WIDTH-1:0];
          end else begin
            cmd_error_d = 1'b1;
          end
        end
        OpStart: begin
          if (idle_or_paused) begin
            if (cmd_delay == '0) begin
              state_d      = StRunning;
              auto_start_d = 1'b1;
            end else begin
              state_d = StArmed;
              delay_d = cmd_delay - DELAY_WIDTH'(1);
            end
          end else begin
            cmd_error_d = 1'b1;
          end
        end
        OpStop: begin
          // Freeze the counter and cancel any pending arm, including one expiring now.
          if (!idle_or_paused) begin
            state_d      = StPaused;
            counter_d    = counter_q;
            delay_d      = '0;
            auto_start_d = 1'b0;
            wrap_error_d = wrap_error_q;
          end
        end
        OpClear: begin
          state_d      = StIdle;
          counter_d    = '0;
          delay_d      = '0;
          auto_start_d = 1'b0;
          wrap_error_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      delay_q      <= '0;
      auto_start_q <= 1'b0;
      running_q    <= 1'b0;
      cmd_error_q  <= 1'b0;
      wrap_error_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      delay_q      <= delay_d;
      auto_start_q <= auto_start_d;
      running_q    <= (state_d == StRunning);
      cmd_error_q  <= cmd_error_d;
      wrap_error_q <= wrap_error_d;
      cmd_ready_q  <= 1'b1;
    end
  end

  assign counter    = counter_q;
  assign auto_start = auto_start_q;
  assign running    = running_q;
  assign state      = state_q;
  assign cmd_error  = cmd_error_q;
  assign wrap_error = wrap_error_q;
  assign cmd_ready  = cmd_ready_q;

endmodule

// File: tb/tb_rto_time_controller.sv
module tb_rto_time_controller;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_data;
  logic [63:0] counter;
  logic        auto_start;
  logic        running;
  logic [1:0]  state;
  logic        cmd_error;
  logic        wrap_error;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] LOAD = 2'd0, START = 2'd1, STOP = 2'd2, CLEAR = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2, S_PAUSED = 2'd3;

  rto_time_controller #(
    .COUNTER_WIDTH(64),
    .DELAY_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .counter   (counter),
    .auto_start(auto_start),
    .running   (running),
    .state     (state),
    .cmd_error (cmd_error),
    .wrap_error(wrap_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [63:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_data  = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Common checks of the RUNNING-related outputs.
  task automatic check_run(input string tag, input logic [1:0] st, input logic [63:0] cnt,
                           input logic as);
    check({tag, ".state"}, 64'(state), 64'(st));
    check({tag, ".counter"}, counter, cnt);
    check({tag, ".auto_start"}, 64'(auto_start), 64'(as));
    check({tag, ".running"}, 64'(running), 64'(st == S_RUN));
  endtask

  initial begin
    logic seen_as;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = LOAD;
    cmd_data  = '0;
    step(); step(); step();

    // Reset values
    check_run("rst", S_IDLE, 64'h0, 1'b0);
    check("rst.cmd_ready", 64'(cmd_ready), 64'h0);
    check("rst.cmd_error", 64'(cmd_error), 64'h0);
    check("rst.wrap_error", 64'(wrap_error), 64'h0);
    reset = 1'b0;
    step();
    check("rdy_after_rst", 64'(cmd_ready), 64'h1);

    // LOAD then START with zero delay
    cmd(LOAD, 64'h100);
    check_run("load", S_IDLE, 64'h100, 1'b0);
    cmd(START, 64'h0);
    check_run("start0", S_RUN, 64'h100, 1'b1);
    step();
    check_run("start0+1", S_RUN, 64'h101, 1'b0);
    step();
    check_run("start0+2", S_RUN, 64'h102, 1'b0);

    // Illegal commands while RUNNING: single error pulse, counting continues
    cmd(LOAD, 64'h5);
    check_run("ill_load", S_RUN, 64'h103, 1'b0);
    check("ill_load.err", 64'(cmd_error), 64'h1);
    step();
    check("ill_load.err_clr", 64'(cmd_error), 64'h0);
    check("ill_load.cnt", counter, 64'h104);
    cmd(START, 64'h0);
    check_run("ill_start", S_RUN, 64'h105, 1'b0);
    check("ill_start.err", 64'(cmd_error), 64'h1);

    // CLEAR then START with delay 5
    cmd(CLEAR, 64'h0);
    check_run("clear", S_IDLE, 64'h0, 1'b0);
    check("clear.err", 64'(cmd_error), 64'h0);
    cmd(START, 64'h5);
    check_run("d5.n1", S_ARMED, 64'h0, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      step();
      check_run($sformatf("d5.n%0d", i), S_ARMED, 64'h0, 1'b0);
    end
    step();
    check_run("d5.n6", S_RUN, 64'h0, 1'b1);
    step();
    check_run("d5.n7", S_RUN, 64'h1, 1'b0);

    // Pause and resume around 0x50
    cmd(STOP, 64'h0);
    check_run("stop1", S_PAUSED, 64'h1, 1'b0);
    cmd(STOP, 64'h0);
    check_run("stop_noop", S_PAUSED, 64'h1, 1'b0);
    check("stop_noop.err", 64'(cmd_error), 64'h0);
    cmd(LOAD, 64'h4E);
    cmd(START, 64'h0);
    check_run("r4e", S_RUN, 64'h4E, 1'b1);
    step();
    step();
    check_run("r50", S_RUN, 64'h50, 1'b0);
    cmd(STOP, 64'h0);
    check_run("p50", S_PAUSED, 64'h50, 1'b0);
    step();
    check_run("p50.hold", S_PAUSED, 64'h50, 1'b0);
    cmd(START, 64'h0);
    check_run("resume", S_RUN, 64'h50, 1'b1);
    step();
    check_run("resume+1", S_RUN, 64'h51, 1'b0);

    // Wrap at all-ones
    cmd(STOP, 64'h0);
    cmd(LOAD, 64'hFFFF_FFFF_FFFF_FFFE);
    cmd(START, 64'h0);
    check_run("wrap.fe", S_RUN, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    step();
    check_run("wrap.ff", S_RUN, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("wrap.ff.flag", 64'(wrap_error), 64'h0);
    step();
    check_run("wrap.0", S_RUN, 64'h0, 1'b0);
    check("wrap.0.flag", 64'(wrap_error), 64'h1);
    step();
    check("wrap.1.flag", 64'(wrap_error), 64'h1);
    check("wrap.1.cnt", counter, 64'h1);
    cmd(CLEAR, 64'h0);
    check_run("wrap.clear", S_IDLE, 64'h0, 1'b0);
    check("wrap.clear.flag", 64'(wrap_error), 64'h0);

    // STOP in the cycle the arm delay reads 0
    cmd(START, 64'h2);
    check_run("sx.arm", S_ARMED, 64'h0, 1'b0);
    step();
    cmd(STOP, 64'h0);
    check_run("sx.stop", S_PAUSED, 64'h0, 1'b0);
    step();
    check_run("sx.after", S_PAUSED, 64'h0, 1'b0);

    // LOAD in the cycle the arm delay reads 0: rejected, expiry proceeds
    cmd(START, 64'h2);
    step();
    cmd(LOAD, 64'h77);
    check_run("lx", S_RUN, 64'h0, 1'b1);
    check("lx.err", 64'(cmd_error), 64'h1);
    step();
    check_run("lx+1", S_RUN, 64'h1, 1'b0);
    check("lx+1.err", 64'(cmd_error), 64'h0);

    // Reset while ARMED with a long delay pending
    cmd(STOP, 64'h0);
    cmd(START, 64'd1000);
    step();
    step();
    check("rx.armed", 64'(state), 64'(S_ARMED));
    reset = 1'b1;
    step();
    check_run("rx.rst", S_IDLE, 64'h0, 1'b0);
    check("rx.rst.rdy", 64'(cmd_ready), 64'h0);
    reset = 1'b0;
    step();
    check("rx.rdy", 64'(cmd_ready), 64'h1);
    seen_as = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (auto_start || state != S_IDLE) seen_as = 1'b1;
    end
    check("rx.no_start", 64'(seen_as), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
